// File: rtl/chain_outbox_arbiter.sv
// Purpose : round-robin arbiter sharing the chain outbox byte stream between N_REQ message sources.
// Latency : request to first grant is 2 cycles (IDLE, CHECK); the outbox byte follows src_rd by 1 cycle.
// Backpressure: outbox_ready gates only the start of a message; once committed, a message streams to completion.
//
// Ports:
//   clk_100, rst_n       clock, asynchronous active-low reset
//   req/req_len/src_d    per-requester pending flag, length (11b each) and FWFT data byte (8b each)
//   src_rd               per-requester byte-consumed strobe
//   grant/done/drop      one-hot owner, completion pulse, rejection pulse (with done)
//   underrun             sticky: owner dropped req mid-message
//   outbox_ready         chain writer can accept a new message
//   outbox_txd/txdv/txe  registered outbox byte stream, txe marks the last byte
module chain_outbox_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 64,
  parameter int GAP     = 8
) (
  input  logic                 clk_100,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [11*N_REQ-1:0]  req_len,
  input  logic [8*N_REQ-1:0]   src_d,
  output logic [N_REQ-1:0]     src_rd,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 drop,
  output logic                 underrun,
  input  logic                 outbox_ready,
  output logic [7:0]           outbox_txd,
  output logic                 outbox_txdv,
  output logic                 outbox_txe
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = $clog2(GAP + 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Context of the message currently being arbitrated or sent.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [10:0]   len;
  } msg_t;

  state_t         state_q;
  state_t         state_d;
  msg_t           msg_q;
  logic [IW-1:0]  ptr_q;
  logic [10:0]    cnt_q;
  logic [GW-1:0]  gap_q;

  logic [10:0]    len_arr [N_REQ];
  logic [7:0]     dat_arr [N_REQ];

  logic [N_REQ-1:0] eligible;
  logic             sel_vld;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    cand;

  logic             reject;
  logic             last_byte;
  logic             gap_end;
  logic [IW-1:0]    ptr_nxt;
  logic             cur_req;
  logic [7:0]       cur_dat;
  logic [N_REQ-1:0] idx_oh;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign len_arr[g] = req_len[g*11 +: 11];
    assign dat_arr[g] = src_d[g*8 +: 8];
  end

  // A requester whose done is pulsing this cycle may not have dropped req
  // yet; masking it keeps a just-rejected request from being picked again.
  assign eligible = req & ~done;

  // Round-robin scan starting at the pointer.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % N_REQ);
      if (!sel_vld && eligible[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign cur_req   = req[msg_q.idx];
  assign cur_dat   = dat_arr[msg_q.idx];
  assign idx_oh    = ONE << msg_q.idx;
  assign reject    = (msg_q.len == 11'd0) || (msg_q.len > 11'(MAX_LEN));
  // len is known non-zero once in SEND, so len-1 cannot wrap.
  assign last_byte = (state_q == ST_SEND) && (cnt_q == msg_q.len - 11'd1);
  assign gap_end   = (gap_q == GW'(GAP - 1));
  assign ptr_nxt   = (msg_q.idx == IW'(N_REQ - 1)) ? '0 : msg_q.idx + 1'b1;

  // State register.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (outbox_ready && sel_vld) state_d = ST_CHECK;
      ST_CHECK: state_d = reject ? ST_IDLE : ST_SEND;
      ST_SEND:  if (last_byte) state_d = ST_GAP;
      // The txe cycle is the first GAP-state cycle; the final idle cycle is IDLE.
      ST_GAP:   if (gap_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Combinational outputs.
  always_comb begin
    grant  = '0;
    src_rd = '0;
    if (state_q == ST_SEND) begin
      grant = idx_oh;
      if (cur_req) src_rd = idx_oh;
    end
  end

  // Message context, pointer and counters.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      msg_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (outbox_ready && sel_vld) begin
            msg_q.idx <= sel_idx;
            msg_q.len <= len_arr[sel_idx];
          end
        end
        ST_CHECK: begin
          cnt_q <= '0;
          if (reject) ptr_q <= ptr_nxt;
        end
        ST_SEND: begin
          cnt_q <= cnt_q + 11'd1;
          if (last_byte) begin
            ptr_q <= ptr_nxt;
            gap_q <= '0;
          end
        end
        ST_GAP: begin
          gap_q <= gap_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outbox stream and status pulses.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      outbox_txd  <= '0;
      outbox_txdv <= 1'b0;
      outbox_txe  <= 1'b0;
      done        <= '0;
      drop        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      outbox_txd  <= '0;
      outbox_txdv <= 1'b0;
      outbox_txe  <= 1'b0;
      done        <= '0;
      drop        <= 1'b0;
      if (state_q == ST_CHECK && reject) begin
        done <= idx_oh;
        drop <= 1'b1;
      end
      if (state_q == ST_SEND) begin
        // A vanished requester is padded with zeros so the frame keeps its length.
        outbox_txdv <= 1'b1;
        outbox_txd  <= cur_req ? cur_dat : 8'h00;
        outbox_txe  <= last_byte;
        if (last_byte) done <= idx_oh;
        if (!cur_req) underrun <= 1'b1;
      end
    end
  end

endmodule
